data_mem_responder: RTL and testbench

- Responder end of the core's data-memory interface: serves load/store requests that the datapath issues after the ALU computes an address.
- Replaces the single-cycle combinational RAM with a multi-cycle backing store of 64-bit doublewords.
- Uses valid/ready request and response channels and a configurable access latency.

---
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and response channels.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned requests with rsp_err instead of accessing memory.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH);
  // wide enough to hold LATENCY-1, the edges still to go after acceptance
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [63:0]   mem [DEPTH];

  logic          lat_write;
  logic [IW-1:0] lat_idx;
  logic [63:0]   lat_wdata;
  logic          lat_mis;

  logic          req_mis;
  logic          accept;
  logic          access;
  logic          a_write;
  logic          a_mis;
  logic [IW-1:0] a_idx;
  logic [63:0]   a_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = |req_addr[2:0];
  logic unused_addr;
  assign unused_addr = ^req_addr[63:IW+3];
`else
  assign req_mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{req_addr[63:IW+3], req_addr[2:0]};
`endif

  assign req_ready = (state == IDLE);
  // no acceptance while reset is held, so a single-latency store cannot commit during reset
  assign accept    = req_valid && req_ready && !rst;

  always_comb begin
    access  = 1'b0;
    a_write = lat_write;
    a_idx   = lat_idx;
    a_wdata = lat_wdata;
    a_mis   = lat_mis;
    if (LATENCY == 1) begin
      access  = accept;
      a_write = req_write;
      a_idx   = req_addr[IW+2:3];
      a_wdata = req_wdata;
      a_mis   = req_mis;
    end else begin
      access  = (state == WAIT) && (cnt == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= (LATENCY == 1) ? RESP : WAIT;
            cnt   <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (a_write || a_mis) ? 64'd0 : mem[a_idx];
        rsp_err   <= a_mis;
      end
    end
  end

  // request latch and storage are deliberately not reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_idx   <= req_addr[IW+2:3];
      lat_wdata <= req_wdata;
      lat_mis   <= req_mis;
    end
    if (access && a_write && !a_mis) begin
      mem[a_idx] <= a_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: two instances (latency 2 and 4) against an array model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int L0    = 2;
  localparam int L1    = 4;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_valid_v [2];
  logic        req_ready_v [2];
  logic        rsp_valid_v [2];
  logic        rsp_ready_v [2];
  logic        rsp_err_v   [2];
  logic [63:0] rsp_rdata_v [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit [63:0] mem_m [2][DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(L0)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]),
    .rsp_rdata(rsp_rdata_v[0]), .rsp_err(rsp_err_v[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(L1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]),
    .rsp_rdata(rsp_rdata_v[1]), .rsp_err(rsp_err_v[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? L0 : L1;
  endfunction

  // doubleword index with wrap: plain byte-address arithmetic
  function automatic int idx_of(logic [63:0] a);
    return int'((a / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic bit is_mis(logic [63:0] a);
    return ALIGN && ((a % 64'd8) != 64'd0);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present a request and return 1ns after the accepting edge
  task automatic issue(int d, logic wr, logic [63:0] a, logic [63:0] wd, logic rr, bit keep);
    int k;
    k = 0;
    @(negedge clk);
    req_write = wr;
    req_addr = a;
    req_wdata = wd;
    req_valid_v[d] = 1'b1;
    rsp_ready_v[d] = rr;
    while (!req_ready_v[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", 64'(k < 50), 64'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid_v[d] = 1'b0;
  endtask

  task automatic await_rsp(int d, logic [63:0] er, logic ee, int hold);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid_v[d]) break;
    end
    check("latency", 64'(n), 64'(lat(d)));
    check("rdata", rsp_rdata_v[d], er);
    check("err", 64'(rsp_err_v[d]), 64'(ee));
    check("ready_busy", 64'(req_ready_v[d]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid_v[d]), 64'd1);
      check("hold_rdata", rsp_rdata_v[d], er);
      check("hold_err", 64'(rsp_err_v[d]), 64'(ee));
      check("hold_ready", 64'(req_ready_v[d]), 64'd0);
    end
    rsp_ready_v[d] = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_drop", 64'(rsp_valid_v[d]), 64'd0);
    check("idle_ready", 64'(req_ready_v[d]), 64'd1);
    check("rdata_keep", rsp_rdata_v[d], er);
    rsp_ready_v[d] = 1'b0;
  endtask

  task automatic txn(int d, logic wr, logic [63:0] a, logic [63:0] wd, int hold);
    logic mis;
    logic [63:0] er;
    mis = is_mis(a);
    er = (wr || mis) ? 64'd0 : mem_m[d][idx_of(a)];
    issue(d, wr, a, wd, logic'(hold == 0), 1'b0);
    await_rsp(d, er, mis, hold);
    if (wr && !mis) mem_m[d][idx_of(a)] = wd;
  endtask

  task automatic reset_in_resp(int d, logic wr, logic [63:0] a, logic [63:0] wd);
    int n;
    n = 0;
    issue(d, wr, a, wd, 1'b0, 1'b0);
    while (n < 40 && !rsp_valid_v[d]) begin
      @(negedge clk);
      n++;
    end
    check("resp_reached", 64'(rsp_valid_v[d]), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready_v[d]), 64'd1);
    check("rst_valid", 64'(rsp_valid_v[d]), 64'd0);
    check("rst_rdata", rsp_rdata_v[d], 64'd0);
    check("rst_err", 64'(rsp_err_v[d]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    if (wr && !is_mis(a)) mem_m[d][idx_of(a)] = wd;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int idxs [8];
    logic [63:0] a;
    logic wr;

    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    for (int d = 0; d < 2; d++) begin
      req_valid_v[d] = 1'b0;
      rsp_ready_v[d] = 1'b0;
    end

    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", 64'(req_ready_v[d]), 64'd1);
      check("reset_valid", 64'(rsp_valid_v[d]), 64'd0);
      check("reset_rdata", rsp_rdata_v[d], 64'd0);
      check("reset_err", 64'(rsp_err_v[d]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // store then load with rsp_ready held high throughout
    txn(0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, 0);
    txn(0, 1'b0, 64'h10, 64'h0, 0);

    // backpressure with the next request already waiting (its fields change during WAIT)
    issue(0, 1'b0, 64'h10, 64'h0, 1'b0, 1'b1);
    req_write = 1'b1;
    req_addr = 64'h18;
    req_wdata = 64'h1234;
    await_rsp(0, 64'hDEADBEEFCAFEF00D, 1'b0, 3);
    @(posedge clk);
    #1;
    check("held_accept", 64'(req_ready_v[0]), 64'd0);
    req_valid_v[0] = 1'b0;
    await_rsp(0, 64'd0, 1'b0, 0);
    mem_m[0][idx_of(64'h18)] = 64'h1234;
    txn(0, 1'b0, 64'h18, 64'h0, 1);

    // wrap-around
    txn(0, 1'b1, 64'h800, 64'h1, 1);
    txn(0, 1'b0, 64'h0, 64'h0, 0);

    // async reset while in RESP: load result cleared, committed store kept
    reset_in_resp(0, 1'b0, 64'h10, 64'h0);
    reset_in_resp(0, 1'b1, 64'h30, 64'h99);
    txn(0, 1'b0, 64'h30, 64'h0, 1);

    // misaligned store; with the alignment check it is flagged and dropped
    txn(0, 1'b1, 64'h13, 64'h77, 1);
    txn(0, 1'b0, 64'h10, 64'h0, 0);

    // reset mid-WAIT on the latency-4 instance drops the store
    txn(1, 1'b1, 64'h20, 64'hAA, 0);
    issue(1, 1'b1, 64'h20, 64'h55, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("wait_rst_ready", 64'(req_ready_v[1]), 64'd1);
    check("wait_rst_valid", 64'(rsp_valid_v[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wait_rst_quiet", 64'(rsp_valid_v[1]), 64'd0);
    end
    txn(1, 1'b0, 64'h20, 64'h0, 0);

    // randomized traffic over a small set of indices, random upper and low address bits
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        idxs[i] = $urandom_range(0, DEPTH - 1);
        a = {$urandom(), $urandom()};
        a[10:3] = 8'(idxs[i]);
        a[2:0] = 3'd0;
        txn(d, 1'b1, a, {$urandom(), $urandom()}, $urandom_range(0, 2));
      end
      for (int i = 0; i < 24; i++) begin
        a = {$urandom(), $urandom()};
        a[10:3] = 8'(idxs[$urandom_range(0, 7)]);
        a[2:0] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        wr = logic'($urandom_range(0, 1));
        txn(d, wr, a, {$urandom(), $urandom()}, $urandom_range(0, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
